// File: rtl/fd_reg.sv
// fd_reg: Fetch/Decode pipeline register with stall, flush, exception redirect,
// fetch address-error detection and a saturating stall counter.
module fd_reg #(
  parameter logic [31:0] PC_RESET   = 32'h0000_3000,
  parameter logic [31:0] PC_LO      = 32'h0000_3000,
  parameter logic [31:0] PC_HI      = 32'h0000_6FFC,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [4:0]  EXC_ADEL   = 5'd4,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic             req,
  input  logic [31:0]      f_PC,
  input  logic [31:0]      f_Instr,
  input  logic             f_BD,
  output logic [31:0]      d_PC,
  output logic [31:0]      d_Instr,
  output logic             d_BD,
  output logic [4:0]       d_ExcCode,
  output logic             d_Valid,
  output logic [CNT_W-1:0] stall_cnt
);
  logic [31:0] pc_q, pc_d, instr_q, instr_d;
  logic [4:0] exc_q, exc_d;
  logic bd_q, bd_d, valid_q, valid_d, adel, kill, stall;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign adel = (|f_PC[1:0]) || (f_PC < PC_LO) || (f_PC > PC_HI);
  assign kill = req || flush;
  assign stall = !kill && !en;
  // A faulting fetch still loads its PC so it can become EPC downstream.
  always_comb begin
    pc_d = req ? HANDLER_PC : (flush || en) ? f_PC : pc_q;
    instr_d = kill ? '0 : en ? (adel ? '0 : f_Instr) : instr_q;
    bd_d = kill ? 1'b0 : en ? f_BD : bd_q;
    exc_d = kill ? '0 : en ? (adel ? EXC_ADEL : '0) : exc_q;
    valid_d = kill ? 1'b0 : en ? 1'b1 : valid_q;
    cnt_d = (stall && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= PC_RESET;
      instr_q <= '0;
      bd_q <= 1'b0;
      exc_q <= '0;
      valid_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      pc_q <= pc_d;
      instr_q <= instr_d;
      bd_q <= bd_d;
      exc_q <= exc_d;
      valid_q <= valid_d;
      cnt_q <= cnt_d;
    end
  end
  assign d_PC = pc_q;
  assign d_Instr = instr_q;
  assign d_BD = bd_q;
  assign d_ExcCode = exc_q;
  assign d_Valid = valid_q;
  assign stall_cnt = cnt_q;
endmodule

// File: tb/tb_fd_reg.sv
// tb_fd_reg: directed plus randomized checks of fd_reg against a rule-level model.
module tb_fd_reg;
  localparam int CNT_W = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  logic clk = 1'b0;
  logic reset, en, flush, req, f_BD;
  logic [31:0] f_PC, f_Instr;
  logic [31:0] d_PC, d_Instr;
  logic d_BD, d_Valid;
  logic [4:0] d_ExcCode;
  logic [CNT_W-1:0] stall_cnt;
  int ncmp = 0, nerr = 0;
  logic [31:0] m_pc, m_instr;
  logic m_bd, m_valid;
  logic [4:0] m_exc;
  int m_cnt;
  fd_reg #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .req(req),
    .f_PC(f_PC), .f_Instr(f_Instr), .f_BD(f_BD),
    .d_PC(d_PC), .d_Instr(d_Instr), .d_BD(d_BD), .d_ExcCode(d_ExcCode),
    .d_Valid(d_Valid), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bit bad_addr(input logic [31:0] pc);
    return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6FFC);
  endfunction
  // Apply one cycle of inputs, advance the model by the priority rules, then compare.
  task automatic step(input string tag, input logic r, input logic q, input logic fl,
                      input logic e, input logic [31:0] pc, input logic [31:0] ins, input logic bd);
    @(negedge clk);
    reset = r; req = q; flush = fl; en = e; f_PC = pc; f_Instr = ins; f_BD = bd;
    @(posedge clk);
    if (r) begin
      m_pc = 32'h3000; m_instr = 0; m_bd = 0; m_exc = 0; m_valid = 0; m_cnt = 0;
    end else if (q) begin
      m_pc = 32'h4180; m_instr = 0; m_bd = 0; m_exc = 0; m_valid = 0;
    end else if (fl) begin
      m_pc = pc; m_instr = 0; m_bd = 0; m_exc = 0; m_valid = 0;
    end else if (!e) begin
      if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end else begin
      m_pc = pc; m_bd = bd; m_valid = 1;
      m_exc = bad_addr(pc) ? 5'd4 : 5'd0;
      m_instr = bad_addr(pc) ? 32'h0 : ins;
    end
    #1;
    chk({tag, ".pc"}, d_PC, m_pc);
    chk({tag, ".instr"}, d_Instr, m_instr);
    chk({tag, ".bd"}, {31'b0, d_BD}, {31'b0, m_bd});
    chk({tag, ".exc"}, {27'b0, d_ExcCode}, {27'b0, m_exc});
    chk({tag, ".valid"}, {31'b0, d_Valid}, {31'b0, m_valid});
    chk({tag, ".cnt"}, {{(32-CNT_W){1'b0}}, stall_cnt}, m_cnt);
  endtask
  initial begin
    logic [31:0] pc;
    reset = 1; req = 0; flush = 0; en = 0; f_PC = 0; f_Instr = 0; f_BD = 0;
    m_pc = 'x; m_instr = 'x; m_bd = 'x; m_exc = 'x; m_valid = 'x; m_cnt = 0;
    step("reset", 1, 0, 0, 0, 32'h0, 32'h0, 0);
    chk("reset_pc_const", d_PC, 32'h3000);
    step("load0", 0, 0, 0, 1, 32'h3000, 32'h3C01_0001, 0);
    chk("load0_instr_const", d_Instr, 32'h3C01_0001);
    step("load1", 0, 0, 0, 1, 32'h3004, 32'h2421_0005, 1);
    for (int i = 0; i < 3; i++) step("stall", 0, 0, 0, 0, 32'h3008, 32'h1111_1111, 0);
    chk("stall3_cnt_const", {{(32-CNT_W){1'b0}}, stall_cnt}, 3);
    chk("stall3_pc_const", d_PC, 32'h3004);
    step("flush_ov_stall", 0, 0, 1, 0, 32'h3010, 32'h2222_2222, 1);
    chk("flush_pc_const", d_PC, 32'h3010);
    step("load2", 0, 0, 0, 1, 32'h3014, 32'h3333_3333, 1);
    step("req_flush", 0, 1, 1, 1, 32'h3020, 32'h4444_4444, 1);
    chk("req_pc_const", d_PC, 32'h4180);
    step("adel_mis", 0, 0, 0, 1, 32'h3002, 32'h5555_5555, 0);
    chk("adel_mis_exc_const", {27'b0, d_ExcCode}, 4);
    step("adel_hi", 0, 0, 0, 1, 32'h7000, 32'h6666_6666, 0);
    step("legal_hi", 0, 0, 0, 1, 32'h6FFC, 32'h7777_7777, 1);
    chk("legal_hi_exc_const", {27'b0, d_ExcCode}, 0);
    step("adel_lo", 0, 0, 0, 1, 32'h2FFC, 32'h8888_8888, 0);
    step("legal_lo", 0, 0, 0, 1, 32'h3000, 32'h9999_9999, 0);
    for (int i = 0; i < CNT_MAX + 4; i++) step("sat", 0, 0, 0, 0, 32'h3000 + 4 * i, 32'hA5A5_0000 + i, 1);
    chk("sat_cnt_const", {{(32-CNT_W){1'b0}}, stall_cnt}, CNT_MAX);
    step("sat_req", 0, 1, 0, 0, 32'h3100, 32'h1, 0);
    step("sat_flush", 0, 0, 1, 0, 32'h3104, 32'h2, 0);
    step("sat_hold", 0, 0, 0, 0, 32'h3108, 32'h3, 0);
    step("reset_stall", 1, 0, 0, 0, 32'h3200, 32'h4, 1);
    chk("reset_cnt_const", {{(32-CNT_W){1'b0}}, stall_cnt}, 0);
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0: pc = 32'h3000 + 4 * $urandom_range(0, 32'hFFF);
        1: pc = 32'h6FFC;
        2: pc = 32'h7000;
        3: pc = 32'h2FFC;
        4: pc = 32'h3000 + 4 * $urandom_range(0, 32'hFFF) + $urandom_range(1, 3);
        default: pc = $urandom;
      endcase
      step("rand", $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 6,
           $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 65, pc, $urandom, $urandom_range(0, 1) == 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/fd_reg.md
Name: fd_reg

Overview:
- Pipeline register between the Fetch stage and the Decode stage of the five-stage MIPS core.
- Captures the fetched PC and instruction each cycle and presents them to Decode.
- Supports stall (hold), flush (bubble) and exception-request flush to the handler.
- Detects fetch address errors (AdEL) and tags the instruction as in a branch delay slot.
- Keeps a saturating stall-cycle counter for performance checks.

Parameters:
PC_RESET, 32'h0000_3000, d_PC value after reset
PC_LO, 32'h0000_3000, lowest legal fetch address
PC_HI, 32'h0000_6FFC, highest legal fetch address
HANDLER_PC, 32'h0000_4180, d_PC loaded on exception request
EXC_ADEL, 5'd4, exception code for a fetch address error
CNT_W, 16, stall-counter width

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
en  input  1  1 = load new values; 0 = stall (hold contents)
flush  input  1  insert bubble into Decode (cleared branch / jump squash)
req  input  1  exception/interrupt request; flush and redirect to handler
f_PC  input  32  PC of the instruction currently in Fetch
f_Instr  input  32  instruction word read from IM at f_PC
f_BD  input  1  1 = Fetch instruction is in a branch delay slot
d_PC  output  32  registered PC for Decode
d_Instr  output  32  registered instruction for Decode
d_BD  output  1  registered delay-slot flag
d_ExcCode  output  5  0 = no exception; EXC_ADEL = fetch address error
d_Valid  output  1  1 = real instruction; 0 = bubble
stall_cnt  output  CNT_W  count of stalled cycles since reset, saturating

Behaviour:
- Single clock domain; all outputs are registered, with no combinational path from inputs to outputs.
- Reset (synchronous, highest priority) sets:
  - d_PC = PC_RESET
  - d_Instr = 0, d_BD = 0, d_ExcCode = 0, d_Valid = 0
  - stall_cnt = 0
- Per-cycle priority at the rising edge: reset > req > flush > !en (hold) > load.
- req = 1:
  - d_PC = HANDLER_PC
  - d_Instr = 0, d_BD = 0, d_ExcCode = 0, d_Valid = 0
  - en is ignored.
- flush = 1 (req = 0):
  - d_PC = f_PC
  - d_Instr = 0, d_BD = 0, d_ExcCode = 0, d_Valid = 0
  - flush overrides stall.
- en = 0 (no req, no flush): all d_* outputs hold their values.
- Load (en = 1, no req, no flush):
  - d_PC = f_PC, d_BD = f_BD, d_Valid = 1.
  - Address error condition: f_PC[1:0] != 0, or f_PC < PC_LO, or f_PC > PC_HI (unsigned compare).
  - On address error: d_ExcCode = EXC_ADEL and d_Instr = 0 (nop); d_PC still holds the faulting f_PC for EPC.
  - Otherwise: d_ExcCode = 0 and d_Instr = f_Instr.
- Bubble encoding: d_Instr = 32'h0 (sll $0,$0,0). Downstream stages treat it as a nop regardless of d_Valid.
- stall_cnt:
  - Increments by 1 in any cycle with en = 0, reset = 0, req = 0 and flush = 0.
  - Saturates at all-ones; never wraps.
  - Is not cleared by req or flush.
- Boundary at the legal range: f_PC = PC_HI is legal; PC_HI + 4 raises AdEL; PC_LO - 4 raises AdEL.
- Reset asserted while stalled: reset wins and stall_cnt is cleared.

Test Plan:
- Reset, then en = 1 with f_PC = 0x3000, f_Instr = 0x3C010001 → next edge: d_PC = 0x3000, d_Instr = 0x3C010001, d_Valid = 1, d_ExcCode = 0.
- Load f_PC = 0x3004 / 0x24210005, then en = 0 for 3 cycles while f_PC changes to 0x3008 → d_PC stays 0x3004, d_Instr stays 0x24210005, stall_cnt = 3.
- en = 0 and flush = 1 with f_PC = 0x3010 → d_Instr = 0, d_Valid = 0, d_PC = 0x3010, stall_cnt unchanged.
- req = 1 and flush = 1 together with f_PC = 0x3020 → d_PC = 0x4180, d_Instr = 0, d_Valid = 0.
- Address error cases:
  - f_PC = 0x3002 → d_ExcCode = 4, d_Instr = 0, d_PC = 0x3002, d_Valid = 1.
  - f_PC = 0x7000 → d_ExcCode = 4.
  - f_PC = 0x6FFC → d_ExcCode = 0.
- Force stall_cnt to 16'hFFFE and hold en = 0 for 3 cycles → counter reads 16'hFFFF and stays there. Then reset → d_PC = 0x3000 and stall_cnt = 0.
